// File: rtl/dmem_responder.sv
// Data-memory responder for the core's load/store port: word RAM with fixed wait states,
// plus a mailbox word that records test-program completion and pass/fail.
module dmem_responder #(
  parameter int unsigned DEPTH        = 64,
  parameter int unsigned WAIT_CYCLES  = 2,
  parameter logic [31:0] MAILBOX_ADDR = 32'h54,
  parameter logic [31:0] EXPECT_DATA  = 32'd7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        ready,
  output logic        addr_err,
  output logic        done,
  output logic        pass,
  output logic [15:0] store_count
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [3:0]  WaitInit = 4'(WAIT_CYCLES);
  localparam logic [31:0] RamBytes = 32'(DEPTH * 4);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [15:0] count_q, count_d;

  logic [31:0] mem [DEPTH];

  logic          cur_we;
  logic [31:0]   cur_adr, cur_wdata;
  logic          enter_resp, is_mbox, is_err, ram_we;
  logic [AW-1:0] idx;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    adr_d      = adr_q;
    wdata_d    = wdata_q;
    ready_d    = 1'b0;
    err_d      = 1'b0;
    rdata_d    = 32'h0;
    done_d     = done_q;
    pass_d     = pass_q;
    count_d    = count_q;
    enter_resp = 1'b0;
    ram_we     = 1'b0;

    // With zero wait states the access completes on the accepting edge, so it must be
    // decoded straight from the bus rather than from the latched copy.
    cur_we    = (state_q == StIdle) ? memwrite : we_q;
    cur_adr   = (state_q == StIdle) ? dataadr : adr_q;
    cur_wdata = (state_q == StIdle) ? writedata : wdata_q;
    is_mbox   = (cur_adr == MAILBOX_ADDR);
    is_err    = !is_mbox && ((cur_adr[1:0] != 2'b00) || (cur_adr >= RamBytes));
    idx       = cur_adr[AW+1:2];

    unique case (state_q)
      StIdle: begin
        if (req) begin
          we_d    = memwrite;
          adr_d   = dataadr;
          wdata_d = writedata;
          cnt_d   = WaitInit;
          if (WAIT_CYCLES == 0) begin
            state_d    = StResp;
            enter_resp = 1'b1;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d    = StResp;
          enter_resp = 1'b1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (enter_resp) begin
      ready_d = 1'b1;
      if (is_err) begin
        err_d = 1'b1;
      end else if (cur_we) begin
        // RAM has no reset, so its write enable is gated by reset explicitly.
        ram_we = !is_mbox && reset;
        if (is_mbox && !done_q) begin
          done_d = 1'b1;
          pass_d = (cur_wdata == EXPECT_DATA);
        end
        if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
      end else begin
        rdata_d = is_mbox ? {30'b0, pass_q, done_q} : mem[idx];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      adr_q   <= 32'h0;
      wdata_q <= 32'h0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      count_q <= 16'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem[idx] <= cur_wdata;
  end

  assign readdata    = rdata_q;
  assign ready       = ready_q;
  assign addr_err    = err_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign store_count = count_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance with two wait states, one with none, each
// checked against a word-array model of RAM, mailbox flags and store count.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst [2];
  logic        req [2];
  logic        mw [2];
  logic [31:0] adr [2];
  logic [31:0] wd [2];
  logic [31:0] rd [2];
  logic        rdy [2];
  logic        err [2];
  logic        dn [2];
  logic        ps [2];
  logic [15:0] cnt [2];

  int vectors = 0;
  int errs = 0;

  logic [31:0] mem_m [2][64];
  bit          done_m [2];
  bit          pass_m [2];
  int          cnt_m [2];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(64), .WAIT_CYCLES(2), .MAILBOX_ADDR(32'h54), .EXPECT_DATA(32'd7)) u0 (
    .clk(clk), .reset(rst[0]), .req(req[0]), .memwrite(mw[0]), .dataadr(adr[0]),
    .writedata(wd[0]), .readdata(rd[0]), .ready(rdy[0]), .addr_err(err[0]), .done(dn[0]),
    .pass(ps[0]), .store_count(cnt[0])
  );

  dmem_responder #(.DEPTH(64), .WAIT_CYCLES(0), .MAILBOX_ADDR(32'h54), .EXPECT_DATA(32'd7)) u1 (
    .clk(clk), .reset(rst[1]), .req(req[1]), .memwrite(mw[1]), .dataadr(adr[1]),
    .writedata(wd[1]), .readdata(rd[1]), .ready(rdy[1]), .addr_err(err[1]), .done(dn[1]),
    .pass(ps[1]), .store_count(cnt[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int s);
    done_m[s] = 1'b0;
    pass_m[s] = 1'b0;
    cnt_m[s]  = 0;
  endtask

  task automatic check_flags(input int s, input string tag);
    check({tag, "_done"}, {31'b0, dn[s]}, {31'b0, done_m[s]});
    check({tag, "_pass"}, {31'b0, ps[s]}, {31'b0, pass_m[s]});
    check({tag, "_count"}, {16'b0, cnt[s]}, 32'(cnt_m[s]));
  endtask

  // Apply a model access; returns expected error flag and read data.
  task automatic model_access(input int s, input bit we, input logic [31:0] a,
                              input logic [31:0] d, output bit e_err, output logic [31:0] e_rd);
    bit mb;
    mb    = (a == 32'h54);
    e_err = !mb && ((a % 4) != 0 || a >= 32'd256);
    e_rd  = 32'h0;
    if (!e_err) begin
      if (we) begin
        if (mb && !done_m[s]) begin
          done_m[s] = 1'b1;
          pass_m[s] = (d == 32'd7);
        end
        if (!mb) mem_m[s][a / 4] = d;
        if (cnt_m[s] < 65535) cnt_m[s]++;
      end else begin
        e_rd = mb ? {30'b0, pass_m[s], done_m[s]} : mem_m[s][a / 4];
      end
    end
  endtask

  // One handshake: request held until ready, then latency and response checked.
  task automatic access(input int s, input bit we, input logic [31:0] a, input logic [31:0] d,
                        input string tag);
    int n;
    bit seen;
    bit e_err;
    logic [31:0] e_rd;
    @(negedge clk);
    req[s] = 1'b1; mw[s] = we; adr[s] = a; wd[s] = d;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (rdy[s]) seen = 1'b1;
    end
    req[s] = 1'b0;
    model_access(s, we, a, d, e_err, e_rd);
    check({tag, "_latency"}, 32'(n), (s == 0) ? 32'd3 : 32'd1);
    check({tag, "_addr_err"}, {31'b0, err[s]}, {31'b0, e_err});
    check({tag, "_readdata"}, rd[s], e_rd);
    check_flags(s, tag);
    @(negedge clk);
    check({tag, "_ready_pulse"}, {31'b0, rdy[s]}, 32'd0);
  endtask

  initial begin
    logic [31:0] v, v_old, w0, w8;
    bit store_op;
    logic [31:0] last;
    for (int s = 0; s < 2; s++) begin
      rst[s] = 1'b0; req[s] = 1'b0; mw[s] = 1'b0; adr[s] = 32'h0; wd[s] = 32'h0;
      model_reset(s);
    end
    repeat (2) @(negedge clk);
    check("init_ready", {31'b0, rdy[0]}, 32'd0);
    check_flags(0, "init");
    rst[0] = 1'b1; rst[1] = 1'b1;

    // Basic store/load with two wait states
    access(0, 1'b1, 32'h20, 32'hDEADBEEF, "st20");
    access(0, 1'b0, 32'h20, 32'h0, "ld20");

    // Random aligned RAM traffic, avoiding the mailbox word
    for (int i = 0; i < 6; i++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 63)) * 4;
      if (a == 32'h54) a = 32'h58;
      access(0, 1'b1, a, $urandom, "rnd_st");
      access(0, 1'b0, a, 32'h0, "rnd_ld");
    end

    access(0, 1'b1, 32'h54, 32'd7, "mb_st7");
    access(0, 1'b1, 32'h54, 32'd9, "mb_st9");
    access(0, 1'b0, 32'h54, 32'h0, "mb_ld");

    // Rejected stores leave RAM words 0 and 8 alone
    w0 = $urandom; w8 = $urandom;
    access(0, 1'b1, 32'h0, w0, "w0_st");
    access(0, 1'b1, 32'h20, w8, "w8_st");
    access(0, 1'b1, 32'h22, $urandom, "mis_st");
    access(0, 1'b1, 32'h100, $urandom, "oor_st");
    access(0, 1'b0, 32'h0, 32'h0, "w0_ld");
    access(0, 1'b0, 32'h20, 32'h0, "w8_ld");

    // Reset with a store request pending: outputs held at zero, RAM untouched
    @(negedge clk);
    rst[0] = 1'b0; req[0] = 1'b1; mw[0] = 1'b1; adr[0] = 32'h20; wd[0] = ~w8;
    model_reset(0);
    for (int i = 0; i < 5; i++) begin
      #5;
      check("rst_ready", {31'b0, rdy[0]}, 32'd0);
      check("rst_rdata", rd[0], 32'd0);
      check("rst_err", {31'b0, err[0]}, 32'd0);
      check_flags(0, "rst");
    end
    req[0] = 1'b0;
    @(negedge clk);
    rst[0] = 1'b1;
    access(0, 1'b0, 32'h20, 32'h0, "post_rst_ld");

    access(0, 1'b1, 32'h54, 32'd5, "mb_st5");
    access(0, 1'b0, 32'h54, 32'h0, "mb_ld_fail");

    // Reset pulse while a store is waiting aborts it
    v_old = $urandom;
    access(0, 1'b1, 32'h30, v_old, "abort_pre");
    @(negedge clk);
    req[0] = 1'b1; mw[0] = 1'b1; adr[0] = 32'h30; wd[0] = ~v_old;
    @(posedge clk);
    @(negedge clk);
    rst[0] = 1'b0; req[0] = 1'b0;
    model_reset(0);
    #2 rst[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("abort_no_ready", {31'b0, rdy[0]}, 32'd0);
    end
    check_flags(0, "abort");
    access(0, 1'b0, 32'h30, 32'h0, "abort_ld");

    // Zero wait states, req held: store/load alternate with ready every other cycle
    @(negedge clk);
    store_op = 1'b1;
    v = $urandom;
    last = 32'h0;
    req[1] = 1'b1; mw[1] = 1'b1; adr[1] = 32'h10; wd[1] = v;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i % 2 == 0) begin
        check("b2b_ready", {31'b0, rdy[1]}, 32'd1);
        if (store_op) begin
          last = v;
          cnt_m[1]++;
          check("b2b_st_rdata", rd[1], 32'd0);
        end else begin
          check("b2b_ld_rdata", rd[1], last);
        end
        check("b2b_count", {16'b0, cnt[1]}, 32'(cnt_m[1]));
        store_op = !store_op;
        v = $urandom;
        mw[1] = store_op; wd[1] = v;
      end else begin
        check("b2b_gap", {31'b0, rdy[1]}, 32'd0);
      end
    end
    req[1] = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
